pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Central sequencing block for the 5-stage core: drives the `enable` and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch redirects and multi-cycle data-memory waits, and produces EX-stage operand forwarding selects. A watchdog on memory waits parks the core in a fault state. Saturating stall and flush counters are kept for performance monitoring.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 16: consecutive memory-stall cycles before fault; must be ≥2.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `id_rs1`, `id_rs2` in 5: source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1: the ID instruction actually reads that source.
- `ex_rs1`, `ex_rs2` in 5: source registers of the instruction in EX.
- `ex_rd` in 5: destination of the EX instruction.
- `ex_mem_read` in 1: the EX instruction is a load.
- `ex_branch_taken` in 1: the EX instruction redirects the PC.
- `mem_rd` in 5, `mem_reg_write` in 1: destination and write flag of the MEM instruction.
- `wb_rd` in 5, `wb_reg_write` in 1: destination and write flag of the WB instruction.
- `mem_req` in 1: the MEM instruction accesses data memory.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_enable`, `if_id_enable`, `id_ex_enable`, `ex_mem_enable`, `mem_wb_enable` out 1 each: pipeline register load enables.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush` out 1 each: ORed with `reset` at the register; they load a bubble on the next edge.
- `pc_redirect` out 1: PC mux selects the branch target.
- `forward_a`, `forward_b` out 2 each: 00 = register file, 10 = MEM result, 01 = WB result.
- `mem_fault` out 1: watchdog tripped.
- `stall_cycles`, `flush_count` out `CNT_W` each: saturating counters.

## Operation
- States: RUN, MEM_WAIT, FAULT.
- `mem_stall = mem_req & ~mem_ready`.
- `load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2))`.
- Control outputs are combinational from the state and current inputs. Evaluate in this priority order; the first match wins:
  - FAULT: all enables 0, all flushes 0, `pc_redirect` 0, `mem_fault` 1.
  - `mem_stall`: PC, IF/ID, ID/EX and EX/MEM enables 0. `mem_wb_enable` 1 with `mem_wb_flush` 1. `pc_redirect` 0. A concurrent `ex_branch_taken` stays held in EX and takes effect after the wait.
  - `ex_branch_taken`: all enables 1, `if_id_flush` 1, `id_ex_flush` 1, `pc_redirect` 1. Load-use is ignored because the ID instruction is squashed.
  - `load_use`: `pc_enable` 0, `if_id_enable` 0, `id_ex_enable` 1 with `id_ex_flush` 1, EX/MEM and MEM/WB enables 1.
  - Otherwise: all enables 1, flushes 0, `pc_redirect` 0.
- Forwarding rule for `forward_a` (same for `forward_b` with `ex_rs2`):
  - 10 if `mem_reg_write & mem_rd != 0 & mem_rd == ex_rs1`;
  - else 01 if `wb_reg_write & wb_rd != 0 & wb_rd == ex_rs1`;
  - else 00.
  - Forwarding is independent of state, including FAULT.
- FSM transitions:
  - RUN→MEM_WAIT on `mem_stall`; `wait_cnt` is set to 1.
  - MEM_WAIT stays while `mem_stall`, incrementing `wait_cnt`.
  - MEM_WAIT→RUN when `mem_stall` is 0; `wait_cnt` is cleared.
  - MEM_WAIT→FAULT when `mem_stall` and `wait_cnt == MEM_TIMEOUT-1`.
  - FAULT is left only by `reset`.
- Counters:
  - `stall_cycles` +1 on each edge where `pc_enable == 0` and state ≠ FAULT.
  - `flush_count` +1 on each edge where `pc_redirect == 1`.
  - Both saturate at all-ones.

## Timing
- Control and forwarding outputs have zero-cycle (combinational) latency. State, `wait_cnt` and counters update on the rising edge.
- While `reset` is high, in the cycle after the first edge: state RUN, `wait_cnt` 0, both counters 0.
- With idle inputs the outputs are then: all enables 1, flushes 0, `pc_redirect` 0, forwards 00, `mem_fault` 0.
- `mem_ready` in the same cycle as `mem_req` means zero stall cycles.
- An N-cycle memory wait freezes the front end for exactly N cycles and injects N MEM/WB bubbles.
- A load-use hazard costs exactly one stall cycle. On the next cycle the load is in MEM and its result is forwarded from WB one cycle later.
- A taken branch costs two bubbles (IF/ID and ID/EX).
- Fault timing: `mem_fault` rises on the first cycle after `MEM_TIMEOUT` consecutive `mem_stall` cycles.
- Reset during MEM_WAIT or FAULT: state returns to RUN at that edge.

## Test plan
- Idle after reset: `stall_cycles` 0; all enables 1; forwards 00; `mem_fault` 0.
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5, `id_uses_rs1`=1. Required: `pc_enable`=0, `if_id_enable`=0, `id_ex_flush`=1; `stall_cycles` 1 after the edge. Repeat with `ex_rd`=0: no stall.
- Memory wait with `mem_ready` low for 3 cycles: front end frozen 3 cycles, `mem_wb_flush`=1 each cycle, `stall_cycles`=3, state back to RUN.
- Branch during a memory wait: `pc_redirect` stays 0 until `mem_ready`, then 1 for one cycle with both flushes; `flush_count`=1.
- Forwarding priority: `mem_rd`=`wb_rd`=`ex_rs1`=7, both write flags set → `forward_a`=10. Clear `mem_reg_write` → 01. Set `ex_rs2`=0 with `wb_rd`=0 → `forward_b`=00.
- Watchdog with `MEM_TIMEOUT`=4 and a stalled memory: `mem_fault`=1 and all enables 0 after 4 cycles, persisting when `mem_ready` later rises. `reset` clears the fault.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle between the 5-stage datapath and its hazard controller: pipeline
// register addresses and flags in, enables/flushes/forward selects/monitors out.
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic [4:0]       mem_rd;
  logic             mem_reg_write;
  logic [4:0]       wb_rd;
  logic             wb_reg_write;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_enable;
  logic             if_id_enable;
  logic             id_ex_enable;
  logic             ex_mem_enable;
  logic             mem_wb_enable;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_flush;
  logic             pc_redirect;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic             mem_fault;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_branch_taken,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write, mem_req, mem_ready,
    input  pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
           if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect,
           forward_a, forward_b, mem_fault, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_branch_taken,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write, mem_req, mem_ready,
    output pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
           if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect,
           forward_a, forward_b, mem_fault, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencing for the 5-stage core: load-use stalls, branch squashes,
// data-memory waits with a watchdog, EX forwarding selects and perf counters.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic                          clk,
  input logic                          reset,
  pipeline_hazard_controller_if.slave  bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_count;

  logic mem_stall;
  logic load_use;
  logic pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable;
  logic if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect, mem_fault;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] mem_rd,
    input logic       mem_reg_write,
    input logic [4:0] wb_rd,
    input logic       wb_reg_write
  );
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs)
      return 2'b10;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign mem_stall = bus.mem_req & ~bus.mem_ready;
  assign load_use  = bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                     ((bus.id_uses_rs1 & (bus.ex_rd == bus.id_rs1)) |
                      (bus.id_uses_rs2 & (bus.ex_rd == bus.id_rs2)));

  // Priority: fault > memory wait > branch squash > load-use bubble > run.
  // A branch seen during a memory wait simply stays in EX until the wait ends.
  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    id_ex_enable  = 1'b1;
    ex_mem_enable = 1'b1;
    mem_wb_enable = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_flush  = 1'b0;
    pc_redirect   = 1'b0;
    mem_fault     = 1'b0;
    if (state == FAULT) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_enable = 1'b0;
      mem_fault     = 1'b1;
    end else if (mem_stall) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_flush  = 1'b1;
    end else if (bus.ex_branch_taken) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      pc_redirect   = 1'b1;
    end else if (load_use) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_flush   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      wait_cnt     <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (!mem_stall) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        FAULT: state <= FAULT;
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
      // Frozen cycles while faulted are not stalls; both counters stick at max.
      if (!pc_enable && state != FAULT && stall_cycles != CNT_MAX)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (pc_redirect && flush_count != CNT_MAX)
        flush_count <= flush_count + CNT_W'(1);
    end
  end

  assign bus.pc_enable     = pc_enable;
  assign bus.if_id_enable  = if_id_enable;
  assign bus.id_ex_enable  = id_ex_enable;
  assign bus.ex_mem_enable = ex_mem_enable;
  assign bus.mem_wb_enable = mem_wb_enable;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.mem_wb_flush  = mem_wb_flush;
  assign bus.pc_redirect   = pc_redirect;
  assign bus.mem_fault     = mem_fault;
  assign bus.stall_cycles  = stall_cycles;
  assign bus.flush_count   = flush_count;
  assign bus.forward_a     = fwd_sel(bus.ex_rs1, bus.mem_rd, bus.mem_reg_write,
                                     bus.wb_rd, bus.wb_reg_write);
  assign bus.forward_b     = fwd_sel(bus.ex_rs2, bus.mem_rd, bus.mem_reg_write,
                                     bus.wb_rd, bus.wb_reg_write);

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed plus randomized bench for pipeline_hazard_controller, checked against
// a reference model tracking "faulted" and the run of consecutive memory stalls.
module tb_pipeline_hazard_controller;

  localparam int T  = 4;
  localparam int CW = 6;
  localparam longint CMAX = (64'd1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_controller_if #(.CNT_W(CW)) hif ();

  pipeline_hazard_controller #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif.slave)
  );

  int checks = 0;
  int errors = 0;

  bit     mFaulted = 1'b0;
  int     mRun     = 0;
  longint mStall   = 0;
  longint mFlush   = 0;

  // Control vector: pc, if_id, id_ex, ex_mem, mem_wb enables,
  // if_id, id_ex, mem_wb flushes, redirect, fault.
  function automatic logic [9:0] expCtrl();
    logic stall, lu;
    stall = hif.mem_req && !hif.mem_ready;
    lu = hif.ex_mem_read && hif.ex_rd != 0 &&
         ((hif.id_uses_rs1 && hif.ex_rd == hif.id_rs1) ||
          (hif.id_uses_rs2 && hif.ex_rd == hif.id_rs2));
    if (mFaulted)                return 10'b00000_000_0_1;
    else if (stall)              return 10'b00001_001_0_0;
    else if (hif.ex_branch_taken) return 10'b11111_110_1_0;
    else if (lu)                 return 10'b00111_010_0_0;
    else                         return 10'b11111_000_0_0;
  endfunction

  function automatic logic [1:0] expFwd(input logic [4:0] rs);
    if (hif.mem_reg_write && hif.mem_rd != 0 && hif.mem_rd == rs) return 2'b10;
    if (hif.wb_reg_write && hif.wb_rd != 0 && hif.wb_rd == rs)    return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [9:0] dutCtrl();
    return {hif.pc_enable, hif.if_id_enable, hif.id_ex_enable, hif.ex_mem_enable,
            hif.mem_wb_enable, hif.if_id_flush, hif.id_ex_flush, hif.mem_wb_flush,
            hif.pc_redirect, hif.mem_fault};
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".ctrl"}, 64'(dutCtrl()), 64'(expCtrl()));
    checkVal({tag, ".fwd_a"}, 64'(hif.forward_a), 64'(expFwd(hif.ex_rs1)));
    checkVal({tag, ".fwd_b"}, 64'(hif.forward_b), 64'(expFwd(hif.ex_rs2)));
    checkVal({tag, ".stall_cycles"}, 64'(hif.stall_cycles), 64'(mStall));
    checkVal({tag, ".flush_count"}, 64'(hif.flush_count), 64'(mFlush));
  endtask

  // Check at the falling edge, then advance the model across the rising edge.
  task automatic tick(input string tag);
    logic [9:0] ec;
    logic       stall;
    @(negedge clk);
    checkOutput(tag);
    ec    = expCtrl();
    stall = hif.mem_req && !hif.mem_ready;
    @(posedge clk);
    if (reset) begin
      mFaulted = 1'b0;
      mRun     = 0;
      mStall   = 0;
      mFlush   = 0;
    end else begin
      if (!mFaulted && !ec[9] && mStall < CMAX) mStall++;
      if (ec[1] && mFlush < CMAX) mFlush++;
      if (!mFaulted) begin
        mRun = stall ? mRun + 1 : 0;
        if (mRun == T) mFaulted = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle();
    hif.id_rs1 = 0; hif.id_rs2 = 0; hif.id_uses_rs1 = 0; hif.id_uses_rs2 = 0;
    hif.ex_rs1 = 0; hif.ex_rs2 = 0; hif.ex_rd = 0; hif.ex_mem_read = 0;
    hif.ex_branch_taken = 0; hif.mem_rd = 0; hif.mem_reg_write = 0;
    hif.wb_rd = 0; hif.wb_reg_write = 0; hif.mem_req = 0; hif.mem_ready = 0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    idle();
    tick("reset");
    reset = 1'b0;
  endtask

  task automatic applyStimulus();
    hif.id_rs1          = 5'($urandom_range(0, 3));
    hif.id_rs2          = 5'($urandom_range(0, 3));
    hif.id_uses_rs1     = 1'($urandom_range(0, 1));
    hif.id_uses_rs2     = 1'($urandom_range(0, 1));
    hif.ex_rs1          = 5'($urandom_range(0, 3));
    hif.ex_rs2          = 5'($urandom_range(0, 3));
    hif.ex_rd           = 5'($urandom_range(0, 3));
    hif.ex_mem_read     = 1'($urandom_range(0, 1));
    hif.ex_branch_taken = ($urandom_range(0, 4) == 0);
    hif.mem_rd          = 5'($urandom_range(0, 3));
    hif.mem_reg_write   = 1'($urandom_range(0, 1));
    hif.wb_rd           = 5'($urandom_range(0, 3));
    hif.wb_reg_write    = 1'($urandom_range(0, 1));
    hif.mem_req         = 1'($urandom_range(0, 1));
    hif.mem_ready       = ($urandom_range(0, 3) == 0);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    #1;

    // Idle after reset
    doReset();
    #1;
    checkVal("idle_stall_cycles", 64'(hif.stall_cycles), 64'd0);
    checkVal("idle_ctrl", 64'(dutCtrl()), 64'(10'b11111_000_0_0));
    checkVal("idle_fwd", 64'({hif.forward_a, hif.forward_b}), 64'd0);
    tick("idle");

    // Load-use stall, then the same with ex_rd = 0
    doReset();
    hif.ex_mem_read = 1; hif.ex_rd = 5; hif.id_rs1 = 5; hif.id_uses_rs1 = 1;
    #1;
    checkVal("lu_pc_enable", 64'(hif.pc_enable), 64'd0);
    checkVal("lu_if_id_enable", 64'(hif.if_id_enable), 64'd0);
    checkVal("lu_id_ex_flush", 64'(hif.id_ex_flush), 64'd1);
    tick("lu");
    checkVal("lu_stall_cycles", 64'(hif.stall_cycles), 64'd1);
    hif.ex_rd = 0; hif.id_rs1 = 0;
    #1;
    checkVal("lu_x0_pc_enable", 64'(hif.pc_enable), 64'd1);
    tick("lu_x0");

    // Three-cycle memory wait
    doReset();
    hif.mem_req = 1; hif.mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkVal("mw_pc_enable", 64'(hif.pc_enable), 64'd0);
      checkVal("mw_mem_wb_flush", 64'(hif.mem_wb_flush), 64'd1);
      tick("mw");
    end
    hif.mem_ready = 1;
    #1;
    checkVal("mw_done_pc_enable", 64'(hif.pc_enable), 64'd1);
    checkVal("mw_stall_cycles", 64'(hif.stall_cycles), 64'd3);
    tick("mw_done");
    idle();
    #1;
    checkVal("mw_back_run", 64'(dutCtrl()), 64'(10'b11111_000_0_0));
    tick("mw_run");

    // Branch held during a memory wait
    doReset();
    hif.mem_req = 1; hif.mem_ready = 0; hif.ex_branch_taken = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checkVal("bw_redirect_held", 64'(hif.pc_redirect), 64'd0);
      tick("bw");
    end
    hif.mem_ready = 1;
    #1;
    checkVal("bw_redirect", 64'({hif.pc_redirect, hif.if_id_flush, hif.id_ex_flush}), 64'd7);
    tick("bw_go");
    hif.ex_branch_taken = 0; hif.mem_req = 0;
    checkVal("bw_flush_count", 64'(hif.flush_count), 64'd1);
    tick("bw_after");

    // Forwarding priority
    idle();
    hif.mem_rd = 7; hif.wb_rd = 7; hif.ex_rs1 = 7;
    hif.mem_reg_write = 1; hif.wb_reg_write = 1;
    #1;
    checkVal("fwd_mem", 64'(hif.forward_a), 64'(2'b10));
    hif.mem_reg_write = 0;
    #1;
    checkVal("fwd_wb", 64'(hif.forward_a), 64'(2'b01));
    hif.ex_rs2 = 0; hif.wb_rd = 0;
    #1;
    checkVal("fwd_x0", 64'(hif.forward_b), 64'(2'b00));
    tick("fwd");

    // Watchdog
    doReset();
    hif.mem_req = 1; hif.mem_ready = 0; hif.ex_rs1 = 3; hif.mem_rd = 3; hif.mem_reg_write = 1;
    for (int i = 0; i < T; i++) tick("wd");
    checkVal("wd_fault", 64'(dutCtrl()), 64'(10'b00000_000_0_1));
    checkVal("wd_fwd_in_fault", 64'(hif.forward_a), 64'(2'b10));
    hif.mem_ready = 1;
    tick("wd_ready");
    checkVal("wd_fault_sticky", 64'(hif.mem_fault), 64'd1);
    checkVal("wd_stall_cycles", 64'(hif.stall_cycles), 64'(T));
    doReset();
    checkVal("wd_cleared", 64'(hif.mem_fault), 64'd0);

    // Stall counter saturation
    doReset();
    hif.ex_mem_read = 1; hif.ex_rd = 2; hif.id_rs2 = 2; hif.id_uses_rs2 = 1;
    for (int i = 0; i < 70; i++) tick("sat");
    checkVal("sat_stall_cycles", 64'(hif.stall_cycles), 64'(CMAX));

    // Randomized traffic against the model
    doReset();
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      applyStimulus();
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
